// File: rtl/memory_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package memory_arb_pkg;

  localparam int WORD_BYTES   = 4;
  localparam int STARVE_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    DM_ACC  = 2'd2,
    ERR_RSP = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  // A word access is legal when aligned and the whole word lies inside memory.
  function automatic logic word_addr_ok(input logic [31:0] addr, input logic [31:0] last_word);
    return (addr[1:0] == 2'b00) && (addr <= last_word);
  endfunction

endpackage

// File: rtl/arb_grant_picker.sv
// Picks one requester per cycle: data wins unless fetch has waited too long.
module arb_grant_picker
  import memory_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic dm_req,
  output logic gnt_valid,
  output logic gnt_id
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C   = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] CNT_ONE_C = {{(STARVE_CNT_W-1){1'b0}}, 1'b1};

  logic [STARVE_CNT_W-1:0] starve_cnt_r;
  logic                    gnt_valid_s;
  logic                    gnt_id_s;

  // Priority select; no grant at all while reset is held.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = REQ_DM;
    if (reset) begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = REQ_DM;
    end else if (if_req && dm_req) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = (starve_cnt_r == LIMIT_C) ? REQ_IF : REQ_DM;
    end else if (dm_req) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = REQ_DM;
    end else if (if_req) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = REQ_IF;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = REQ_DM;
    end
  end

  // Counts data grants taken while fetch is waiting, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= {STARVE_CNT_W{1'b0}};
    end else if (!if_req || (gnt_valid_s && (gnt_id_s == REQ_IF))) begin
      starve_cnt_r <= {STARVE_CNT_W{1'b0}};
    end else if (gnt_valid_s && (starve_cnt_r != LIMIT_C)) begin
      starve_cnt_r <= starve_cnt_r + CNT_ONE_C;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign gnt_valid = gnt_valid_s;
  assign gnt_id    = gnt_id_s;

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port word memory between fetch and data stages with a
// fixed 2-cycle accept-to-response latency and one accept per cycle.
module memory_port_arbiter
  import memory_arb_pkg::*;
#(
  parameter int MEM_BYTES    = 1024,
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LAST_WORD_C = 32'(MEM_BYTES - WORD_BYTES);

  arb_state_t  state_r;
  arb_state_t  state_nxt_s;
  logic        gnt_valid_s;
  logic        gnt_id_s;
  logic        if_ack_s;
  logic        dm_ack_s;
  logic [31:0] acc_addr_s;
  logic        acc_we_s;
  logic [31:0] acc_wdata_s;
  logic        rsp_dm_r;
  logic        rsp_store_r;

  arb_grant_picker #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_picker (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .dm_req    (dm_req),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  // Steer the granted requester's address/we/wdata onto the accept path.
  always_comb begin
    if_ack_s    = 1'b0;
    dm_ack_s    = 1'b0;
    acc_addr_s  = if_addr;
    acc_we_s    = 1'b0;
    acc_wdata_s = 32'h0000_0000;
    if (gnt_valid_s && (gnt_id_s == REQ_DM)) begin
      dm_ack_s    = 1'b1;
      acc_addr_s  = dm_addr;
      acc_we_s    = dm_we;
      acc_wdata_s = dm_wdata;
    end else if (gnt_valid_s) begin
      if_ack_s = 1'b1;
    end else begin
      if_ack_s = 1'b0;
      dm_ack_s = 1'b0;
    end
  end

  assign if_ack = if_ack_s;
  assign dm_ack = dm_ack_s;

  // Next access stage for whatever is accepted this cycle.
  always_comb begin
    state_nxt_s = IDLE;
    if (!gnt_valid_s) begin
      state_nxt_s = IDLE;
    end else if (!word_addr_ok(acc_addr_s, LAST_WORD_C)) begin
      state_nxt_s = ERR_RSP;
    end else if (gnt_id_s == REQ_DM) begin
      state_nxt_s = DM_ACC;
    end else begin
      state_nxt_s = IF_ACC;
    end
  end

  // State register, request latch and memory drive (address/data hold outside accesses).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      rsp_dm_r    <= 1'b0;
      rsp_store_r <= 1'b0;
      mem_addr    <= 32'h0000_0000;
      mem_we      <= 1'b0;
      mem_wdata   <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (gnt_valid_s) begin
        rsp_dm_r    <= (gnt_id_s == REQ_DM);
        rsp_store_r <= acc_we_s;
      end
      if ((state_nxt_s == IF_ACC) || (state_nxt_s == DM_ACC)) begin
        mem_addr  <= acc_addr_s;
        mem_wdata <= acc_wdata_s;
      end
      mem_we <= (state_nxt_s == DM_ACC) && acc_we_s;
    end
  end

  // Response registers: capture read data at the close of the access stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'h0000_0000;
      if_err    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= 32'h0000_0000;
      dm_err    <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'h0000_0000;
      if_err    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= 32'h0000_0000;
      dm_err    <= 1'b0;
      case (state_r)
        IF_ACC: begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
        DM_ACC: begin
          dm_rvalid <= 1'b1;
          dm_rdata  <= rsp_store_r ? 32'h0000_0000 : mem_rdata;
        end
        ERR_RSP: begin
          if (rsp_dm_r) begin
            dm_rvalid <= 1'b1;
            dm_err    <= 1'b1;
          end else begin
            if_rvalid <= 1'b1;
            if_err    <= 1'b1;
          end
        end
        default: begin
          if_rvalid <= 1'b0;
          dm_rvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed self-checking bench for memory_port_arbiter with a word-memory model.
module tb_memory_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem_w [0:255];
  logic        pl_we;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_port_arbiter #(.MEM_BYTES(1024), .STARVE_LIMIT(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port memory: combinational read, write at the clock edge.
  assign mem_rdata = mem_w[mem_addr[9:2]];
  always @(posedge clk) begin
    if (pl_we) mem_w[pl_idx] <= pl_data;
    else if (mem_we) mem_w[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pl_we = 1'b1; pl_idx = idx; pl_data = data;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_addr = 32'h44;
    @(negedge clk);
    n_checks++; if (if_ack !== 1'b0) begin n_fail++; $display("FAIL reset_if_ack: got %0h expected 0", if_ack); end
    n_checks++; if (dm_ack !== 1'b0) begin n_fail++; $display("FAIL reset_dm_ack: got %0h expected 0", dm_ack); end
    n_checks++; if ({if_rvalid, dm_rvalid, if_err, dm_err, mem_we} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {if_rvalid, dm_rvalid, if_err, dm_err, mem_we}); end
    n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    n_checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, dm_rdata); end
    tick();
    reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_lone_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    n_checks++; if (if_ack !== 1'b1) begin n_fail++; $display("FAIL fetch_ack: got %0h expected 1", if_ack); end
    n_checks++; if (dm_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_dm_ack: got %0h expected 0", dm_ack); end
    tick(); if_req = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_drive: got %h we=%0h expected 00000010 we=0", mem_addr, mem_we); end
    n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_early_rvalid: got %0h expected 0", if_rvalid); end
    tick();
    @(negedge clk);
    n_checks++; if (if_rvalid !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid: got %0h expected 1", if_rvalid); end
    n_checks++; if (if_rdata !== 32'h8C22_0004) begin n_fail++; $display("FAIL fetch_rdata: got %h expected 8c220004", if_rdata); end
    n_checks++; if (if_err !== 1'b0 || dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_err: got err=%0h dm_rvalid=%0h expected 0/0", if_err, dm_rvalid); end
    tick();
    @(negedge clk);
    n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_len: got %0h expected 0", if_rvalid); end
    tick();
  endtask

  task automatic test_store_load();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (dm_ack !== 1'b1) begin n_fail++; $display("FAIL store_ack: got %0h expected 1", dm_ack); end
    tick(); dm_we = 1'b0; dm_wdata = 32'h0;
    @(negedge clk);
    n_checks++; if (dm_ack !== 1'b1) begin n_fail++; $display("FAIL load_ack: got %0h expected 1", dm_ack); end
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_drive: got we=%0h %h %h expected 1 00000040 deadbeef", mem_we, mem_addr, mem_wdata); end
    tick(); dm_req = 1'b0;
    @(negedge clk);
    n_checks++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h0 || dm_err !== 1'b0) begin n_fail++; $display("FAIL store_rsp: got v=%0h %h e=%0h expected 1 00000000 0", dm_rvalid, dm_rdata, dm_err); end
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL load_drive: got we=%0h %h expected 0 00000040", mem_we, mem_addr); end
    tick();
    @(negedge clk);
    n_checks++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rsp: got v=%0h %h expected 1 deadbeef", dm_rvalid, dm_rdata); end
    tick();
    @(negedge clk);
    n_checks++; if (dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL load_pulse_len: got %0h expected 0", dm_rvalid); end
    tick();
  endtask

  task automatic test_contention();
    logic [5:0] exp_seq;
    exp_seq = 6'b100100;
    if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin if_req = 1'b0; dm_req = 1'b0; end
      @(negedge clk);
      if (i < 6) begin
        n_checks++; if (if_ack !== exp_seq[i] || dm_ack !== !exp_seq[i]) begin n_fail++; $display("FAIL contention_grant[%0d]: got if=%0h dm=%0h expected if=%0h dm=%0h", i, if_ack, dm_ack, exp_seq[i], !exp_seq[i]); end
      end
      if (i >= 2) begin
        n_checks++; if (if_rvalid !== exp_seq[i-2] || dm_rvalid !== !exp_seq[i-2]) begin n_fail++; $display("FAIL contention_rvalid[%0d]: got if=%0h dm=%0h expected if=%0h dm=%0h", i, if_rvalid, dm_rvalid, exp_seq[i-2], !exp_seq[i-2]); end
        if (exp_seq[i-2]) begin
          n_checks++; if (if_rdata !== 32'h3C01_1000) begin n_fail++; $display("FAIL contention_if_data[%0d]: got %h expected 3c011000", i, if_rdata); end
        end else begin
          n_checks++; if (dm_rdata !== 32'h0123_4567) begin n_fail++; $display("FAIL contention_dm_data[%0d]: got %h expected 01234567", i, dm_rdata); end
        end
      end
      tick();
    end
  endtask

  task automatic test_errors();
    logic        t_dm   [5];
    logic        t_we   [5];
    logic [31:0] t_addr [5];
    logic        t_err  [5];
    logic [31:0] t_data [5];
    logic        ack_o, rv_o, err_o;
    logic [31:0] rd_o;
    t_dm[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 32'h041; t_err[0] = 1'b1; t_data[0] = 32'h0;
    t_dm[1] = 1'b0; t_we[1] = 1'b0; t_addr[1] = 32'h3FE; t_err[1] = 1'b1; t_data[1] = 32'h0;
    t_dm[2] = 1'b1; t_we[2] = 1'b1; t_addr[2] = 32'h042; t_err[2] = 1'b1; t_data[2] = 32'h0;
    t_dm[3] = 1'b0; t_we[3] = 1'b0; t_addr[3] = 32'h400; t_err[3] = 1'b1; t_data[3] = 32'h0;
    t_dm[4] = 1'b0; t_we[4] = 1'b0; t_addr[4] = 32'h3FC; t_err[4] = 1'b0; t_data[4] = 32'h0BAD_F00D;
    for (int k = 0; k < 5; k++) begin
      if (t_dm[k]) begin dm_req = 1'b1; dm_we = t_we[k]; dm_addr = t_addr[k]; dm_wdata = 32'hFFFF_0000; end
      else begin if_req = 1'b1; if_addr = t_addr[k]; end
      @(negedge clk);
      ack_o = t_dm[k] ? dm_ack : if_ack;
      n_checks++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL err_ack[%0d]: got %0h expected 1", k, ack_o); end
      tick(); if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL err_mem_we[%0d]: got %0h expected 0", k, mem_we); end
      tick();
      @(negedge clk);
      rv_o = t_dm[k] ? dm_rvalid : if_rvalid;
      err_o = t_dm[k] ? dm_err : if_err;
      rd_o = t_dm[k] ? dm_rdata : if_rdata;
      n_checks++; if (rv_o !== 1'b1 || err_o !== t_err[k] || rd_o !== t_data[k]) begin n_fail++; $display("FAIL err_rsp[%0d]: got v=%0h e=%0h %h expected 1 e=%0h %h", k, rv_o, err_o, rd_o, t_err[k], t_data[k]); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++; if (dm_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack: got %0h expected 1", dm_ack); end
    tick(); dm_req = 1'b0; dm_we = 1'b0; reset = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    n_checks++; if (if_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack_gated: got %0h expected 0", if_ack); end
    tick(); reset = 1'b0;
    @(negedge clk);
    n_checks++; if (dm_rvalid !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped: got v=%0h we=%0h expected 0/0", dm_rvalid, mem_we); end
    n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    n_checks++; if (if_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_fetch_ack: got %0h expected 1", if_ack); end
    tick(); if_req = 1'b0;
    @(negedge clk);
    n_checks++; if (dm_rvalid !== 1'b0 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL rstmid_fetch_drive: got v=%0h %h expected 0 00000010", dm_rvalid, mem_addr); end
    tick();
    @(negedge clk);
    n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h8C22_0004 || if_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_fetch_rsp: got v=%0h %h e=%0h expected 1 8c220004 0", if_rvalid, if_rdata, if_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] b2b [3];
    b2b[0] = 32'h0000_0013; b2b[1] = 32'h2001_0005; b2b[2] = 32'hAC01_0040;
    for (int c = 0; c < 5; c++) begin
      if_req = (c < 3); if_addr = 32'(c * 4);
      @(negedge clk);
      if (c < 3) begin
        n_checks++; if (if_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %0h expected 1", c, if_ack); end
      end
      n_checks++; if (if_rvalid !== (c >= 2)) begin n_fail++; $display("FAIL b2b_rvalid[%0d]: got %0h expected %0h", c, if_rvalid, (c >= 2)); end
      if (c >= 2) begin
        n_checks++; if (if_rdata !== b2b[c-2]) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", c, if_rdata, b2b[c-2]); end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = 32'h0; dm_wdata = 32'h0; pl_we = 1'b0; pl_idx = 8'h0; pl_data = 32'h0;
    for (int i = 0; i < 256; i++) preload(8'(i), 32'h0);
    preload(8'd0,   32'h0000_0013);
    preload(8'd1,   32'h2001_0005);
    preload(8'd2,   32'hAC01_0040);
    preload(8'd4,   32'h8C22_0004);
    preload(8'd8,   32'h3C01_1000);
    preload(8'd17,  32'h0123_4567);
    preload(8'd255, 32'h0BAD_F00D);
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_contention();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares one single-port, byte-addressed, big-endian memory between the instruction-fetch stage and the data (load/store) stage. Accepts at most one request per cycle, drives the shared memory for one cycle, and returns a registered response to the originating requester. Data accesses win by default. A starvation guard keeps fetch from being locked out. Sits between the pipeline's fetch/memory stages and a unified memory of the same organisation as the existing data memory.

## Interface
- MEM_BYTES, 1024: memory size in bytes; legal word addresses are 0 .. MEM_BYTES-4.
- STARVE_LIMIT, 2: consecutive data grants allowed while a fetch request waits.

- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, level
- if_addr  in  32  fetch byte address
- if_ack  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch response valid, 1-cycle pulse
- if_rdata  out  32  fetched instruction
- if_err  out  1  fetch response is an error (qualifies if_rvalid)
- dm_req  in  1  data request, level
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_ack  out  1  data request accepted this cycle (combinational)
- dm_rvalid  out  1  data response valid, 1-cycle pulse (loads and stores)
- dm_rdata  out  32  load data; 0 for stores
- dm_err  out  1  data response is an error
- mem_addr  out  32  shared memory address
- mem_we  out  1  shared memory write enable
- mem_wdata  out  32  shared memory write data
- mem_rdata  in  32  shared memory read data (combinational from mem_addr)

## Operation
- FSM `arb_state_t`: IDLE, IF_ACC, DM_ACC, ERR_RSP. The state is the access stage for the request accepted in the previous cycle. The arbiter can accept a new request in every state.
- Acceptance happens each cycle that is not a reset cycle:
  - Only one of if_req/dm_req high: that requester is accepted.
  - Both high: dm is accepted, unless starve_cnt == STARVE_LIMIT, in which case if is accepted.
  - Neither high: next state is IDLE.
- The accepted requester's ack is high in that cycle only. Its address, we and wdata are latched at the edge.
- Requester handshake: the requester holds req, addr, we and wdata stable until it sees ack. It may keep req high after ack to issue the next request.
- Address check at acceptance: if addr[1:0] != 0 or addr > MEM_BYTES-4, next state is ERR_RSP. No memory access is made.
- Otherwise the next state is IF_ACC or DM_ACC.
- IF_ACC / DM_ACC: mem_addr = latched addr. mem_we = latched we (DM only). mem_wdata = latched wdata. mem_rdata is captured at the closing edge.
- ERR_RSP and IDLE: mem_we = 0. mem_addr and mem_wdata hold their last values.
- Response: in the cycle after an access state, the matching rvalid pulses with rdata and err.
  - Error response: rdata = 0, err = 1.
  - Store response: rdata = 0, err = 0.
- starve_cnt, 2 bits:
  - Increments on each dm acceptance while if_req is high.
  - Clears on any if acceptance, or when if_req is low.
  - Saturates at STARVE_LIMIT.
- Reset mid-operation: state goes to IDLE and the in-flight response is dropped (no rvalid). acks are 0 during reset cycles. starve_cnt goes to 0.

## Timing
- Cycle T: req high and ack high (accept).
- T+1: memory driven; a store takes effect in the memory within T+1.
- T+2: rvalid pulse with data.
- Latency is 2 cycles from accept to response. Throughput is 1 accept per cycle across both requesters.
- Store at T+1 followed by a load of the same address accepted at T+1: the load's access is at T+2 and returns the new data.
- All outputs except if_ack and dm_ack are registered.
- Reset values: all outputs 0, state IDLE.
- Never both acks high in the same cycle. Never both rvalids high in the same cycle.

## Structure
- Package `memory_arb_pkg` holds:
  - `arb_state_t` enum
  - `req_id_t` enum (REQ_IF, REQ_DM)
  - `WORD_BYTES` = 4
  - `STARVE_CNT_W` = 2
- Sub-module `arb_grant_picker` holds the combinational priority select plus the starve_cnt register. Outputs: grant id and grant valid.
- Top level holds the address check, request latch, FSM, memory drive and response registers.

## Test plan
- Lone fetch: if_req=1, if_addr=0x10, memory word at 0x10 = 0x8C220004 -> if_ack at T, if_rvalid=1 and if_rdata=0x8C220004 at T+2, if_err=0.
- Store then load: dm store 0xDEADBEEF to 0x40, then dm load from 0x40 on the next cycle -> load response 0xDEADBEEF at T+3, store response rdata=0.
- Contention and starvation: if_req and dm_req held high continuously -> grant order DM, DM, IF, DM, DM, IF; no simultaneous acks.
- Errors: dm load at 0x41 and fetch at 0x3FE -> err=1 and rdata=0 two cycles after accept; mem_we stays 0.
- Reset mid-access: accept a dm store to 0x80 at T, assert reset at T+1 -> no dm_rvalid, all outputs 0, state IDLE. A fetch after reset is accepted normally.
- Back-to-back fetches: if_req held with addresses 0x0, 0x4, 0x8 -> acks on 3 consecutive cycles and rvalids on 3 consecutive cycles with matching data.
